// File: rtl/l1_bus_arbiter.sv
// Round-robin arbiter sharing one L1 memory bus between the I-cache (client 0)
// and D-cache (client 1); tags requests with their source and routes responses back.
module l1_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic              c0_req_we,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_data,
  input  logic [ID_W-1:0]   c0_req_id,
  output logic              c0_resp_valid,
  input  logic              c0_resp_ready,
  output logic [DATA_W-1:0] c0_resp_data,
  output logic [ID_W-1:0]   c0_resp_id,

  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic              c1_req_we,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_data,
  input  logic [ID_W-1:0]   c1_req_id,
  output logic              c1_resp_valid,
  input  logic              c1_resp_ready,
  output logic [DATA_W-1:0] c1_resp_data,
  output logic [ID_W-1:0]   c1_resp_id,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [ID_W:0]     mem_req_id,

  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [ID_W:0]     mem_resp_id,

  output logic              err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned MID_W = ID_W + 1;

  logic              slot_q,  slot_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [MID_W-1:0]  id_q,    id_d;
  logic [CNT_W-1:0]  cnt0_q,  cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,  cnt1_d;
  logic              last_q,  last_d;
  logic              err_q,   err_d;

  logic elig0, elig1, win1, can_load, accept;
  logic resp_sel, resp_hs, dec0, dec1, zero_hit;

  // Arbitration: lone eligible client wins, otherwise the one not granted last.
  always_comb begin
    elig0        = c0_req_valid & (cnt0_q < CNT_W'(MAX_OUTST));
    elig1        = c1_req_valid & (cnt1_q < CNT_W'(MAX_OUTST));
    win1         = (elig0 & elig1) ? ~last_q : elig1;
    can_load     = ~slot_q | mem_req_ready;
    accept       = can_load & (elig0 | elig1);
    c0_req_ready = accept & ~win1;
    c1_req_ready = accept & win1;
  end

  // Response routing is purely combinational; MSB of the ID owns the response.
  always_comb begin
    resp_sel       = mem_resp_id[ID_W];
    c0_resp_valid  = mem_resp_valid & ~resp_sel;
    c1_resp_valid  = mem_resp_valid & resp_sel;
    mem_resp_ready = resp_sel ? c1_resp_ready : c0_resp_ready;
    c0_resp_data   = mem_resp_data;
    c1_resp_data   = mem_resp_data;
    c0_resp_id     = mem_resp_id[ID_W-1:0];
    c1_resp_id     = mem_resp_id[ID_W-1:0];
    resp_hs        = mem_resp_valid & mem_resp_ready;
  end

  always_comb begin
    slot_d = slot_q;
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (accept) begin
      slot_d = 1'b1;
      last_d = win1;
      we_d   = win1 ? c1_req_we   : c0_req_we;
      addr_d = win1 ? c1_req_addr : c0_req_addr;
      data_d = win1 ? c1_req_data : c0_req_data;
      id_d   = {win1, (win1 ? c1_req_id : c0_req_id)};
    end else if (mem_req_ready) begin
      slot_d = 1'b0;
    end
  end

  // A response to a client with nothing outstanding is flagged, never underflows.
  always_comb begin
    zero_hit = resp_sel ? (cnt1_q == '0) : (cnt0_q == '0);
    dec0     = resp_hs & ~resp_sel & (cnt0_q != '0);
    dec1     = resp_hs &  resp_sel & (cnt1_q != '0);
    cnt0_d   = cnt0_q + CNT_W'(c0_req_ready) - CNT_W'(dec0);
    cnt1_d   = cnt1_q + CNT_W'(c1_req_ready) - CNT_W'(dec1);
    err_d    = err_q | (resp_hs & zero_hit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      id_q   <= id_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign mem_req_valid = slot_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign mem_req_id    = id_q;
  assign err           = err_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Bench for l1_bus_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_l1_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ID_W   = 2;
  localparam int MAX_OUTST       = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              c0_req_valid, c0_req_ready, c0_req_we;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_data;
  logic [ID_W-1:0]   c0_req_id;
  logic              c0_resp_valid, c0_resp_ready;
  logic [DATA_W-1:0] c0_resp_data;
  logic [ID_W-1:0]   c0_resp_id;
  logic              c1_req_valid, c1_req_ready, c1_req_we;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_data;
  logic [ID_W-1:0]   c1_req_id;
  logic              c1_resp_valid, c1_resp_ready;
  logic [DATA_W-1:0] c1_resp_data;
  logic [ID_W-1:0]   c1_resp_id;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [ID_W:0]     mem_req_id;
  logic              mem_resp_valid, mem_resp_ready;
  logic [DATA_W-1:0] mem_resp_data;
  logic [ID_W:0]     mem_resp_id;
  logic              err;

  l1_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
    .c0_req_addr(c0_req_addr), .c0_req_data(c0_req_data), .c0_req_id(c0_req_id),
    .c0_resp_valid(c0_resp_valid), .c0_resp_ready(c0_resp_ready),
    .c0_resp_data(c0_resp_data), .c0_resp_id(c0_resp_id),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
    .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_req_id(c1_req_id),
    .c1_resp_valid(c1_resp_valid), .c1_resp_ready(c1_resp_ready),
    .c1_resp_data(c1_resp_data), .c1_resp_id(c1_resp_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_id(mem_resp_id),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    c0_req_we = 1'b0; c1_req_we = 1'b1;
    c0_req_addr = 32'h100; c0_req_id = 2'd1; c0_req_data = 128'hA0;
    c1_req_addr = 32'h200; c1_req_id = 2'd2; c1_req_data = 128'hB1;
    c0_resp_ready = 1'b0; c1_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; mem_resp_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       c0v, c1v, mrdy;
    logic       e0, e1, emv;
    logic [2:0] eid;
  } vec_t;

  vec_t tv[10];

  // Reference model state for the random phase.
  logic              m_valid, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [ID_W:0]     m_id;
  int                m_cnt[2];
  int                m_last;

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110};
    tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001};
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    tv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110};
    tv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110};
    tv[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110};
    tv[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001};

    do_reset();
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_mem_req_addr",  128'(mem_req_addr),  128'(0));
    chk("rst_mem_req_id",    128'(mem_req_id),    128'(0));
    chk("rst_err",           128'(err),           128'(0));

    // Alternation, back-pressure stall, and reload-on-drain.
    for (int i = 0; i < 10; i++) begin
      c0_req_valid = tv[i].c0v;
      c1_req_valid = tv[i].c1v;
      mem_req_ready = tv[i].mrdy;
      #1;
      chk($sformatf("tbl%0d_c0_ready", i), 128'(c0_req_ready), 128'(tv[i].e0));
      chk($sformatf("tbl%0d_c1_ready", i), 128'(c1_req_ready), 128'(tv[i].e1));
      tick();
      chk($sformatf("tbl%0d_mem_valid", i), 128'(mem_req_valid), 128'(tv[i].emv));
      chk($sformatf("tbl%0d_mem_id", i), 128'(mem_req_id), 128'(tv[i].eid));
      chk($sformatf("tbl%0d_mem_addr", i), 128'(mem_req_addr),
          tv[i].eid[2] ? 128'h200 : 128'h100);
      chk($sformatf("tbl%0d_mem_we", i), 128'(mem_req_we), 128'(tv[i].eid[2]));
    end

    // Fill client 1 to its outstanding limit; client 0 must still be served.
    do_reset();
    mem_req_ready = 1'b1;
    c1_req_valid = 1'b1;
    for (int k = 0; k < MAX_OUTST; k++) begin
      #1;
      chk($sformatf("fill%0d_c1_ready", k), 128'(c1_req_ready), 128'(1));
      tick();
    end
    c0_req_valid = 1'b1;
    #1;
    chk("full_c1_blocked", 128'(c1_req_ready), 128'(0));
    chk("full_c0_granted", 128'(c0_req_ready), 128'(1));
    tick();
    c0_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_id = 3'b110; c1_resp_ready = 1'b1;
    mem_resp_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    #1;
    chk("rsp1_c1_valid", 128'(c1_resp_valid), 128'(1));
    chk("rsp1_c0_valid", 128'(c0_resp_valid), 128'(0));
    chk("rsp1_c1_id",    128'(c1_resp_id),    128'(2'b10));
    chk("rsp1_mem_ready", 128'(mem_resp_ready), 128'(1));
    chk("rsp1_c1_data",  c1_resp_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    chk("rsp1_c0_data",  c0_resp_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    chk("rsp1_c1_still_blocked", 128'(c1_req_ready), 128'(0));
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("rsp1_c1_unblocked", 128'(c1_req_ready), 128'(1));
    c1_req_valid = 1'b0;
    tick();

    // Response to client 0 held off by its ready, then accepted.
    mem_resp_valid = 1'b1; mem_resp_id = 3'b001; c0_resp_ready = 1'b0; c1_resp_ready = 1'b1;
    #1;
    chk("rsp0_mem_ready_low", 128'(mem_resp_ready), 128'(0));
    chk("rsp0_c1_valid",      128'(c1_resp_valid),  128'(0));
    chk("rsp0_c0_valid",      128'(c0_resp_valid),  128'(1));
    chk("rsp0_c0_id",         128'(c0_resp_id),     128'(1));
    tick();
    c0_resp_ready = 1'b1;
    #1;
    chk("rsp0_mem_ready_high", 128'(mem_resp_ready), 128'(1));
    tick();
    chk("rsp0_no_err", 128'(err), 128'(0));

    // Client 0 now has nothing outstanding: a further response is an error.
    tick();
    mem_resp_valid = 1'b0;
    chk("err_set", 128'(err), 128'(1));
    tick(); tick(); tick();
    chk("err_sticky", 128'(err), 128'(1));
    rst = 1'b0;
    #1;
    chk("err_async_clear", 128'(err), 128'(0));
    chk("rst_async_slot", 128'(mem_req_valid), 128'(0));
    tick();
    rst = 1'b1;

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic el0, el1, can_load, g0, g1, hs, exp_mrr;
      int win, sel;
      c0_req_valid  = 1'($urandom_range(0, 3) != 0);
      c1_req_valid  = 1'($urandom_range(0, 3) != 0);
      c0_req_we     = 1'($urandom_range(0, 1));
      c1_req_we     = 1'($urandom_range(0, 1));
      c0_req_addr   = $urandom;
      c1_req_addr   = $urandom;
      c0_req_data   = {$urandom, $urandom, $urandom, $urandom};
      c1_req_data   = {$urandom, $urandom, $urandom, $urandom};
      c0_req_id     = 2'($urandom_range(0, 3));
      c1_req_id     = 2'($urandom_range(0, 3));
      mem_req_ready = 1'($urandom_range(0, 9) < 6);
      c0_resp_ready = 1'($urandom_range(0, 1));
      c1_resp_ready = 1'($urandom_range(0, 1));
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      sel = int'($urandom_range(0, 1));
      if (m_cnt[sel] == 0) sel = 1 - sel;
      mem_resp_valid = 1'((m_cnt[sel] > 0) && ($urandom_range(0, 1) == 1));
      mem_resp_id = {1'(sel), 2'($urandom_range(0, 3))};

      can_load = !m_valid || mem_req_ready;
      el0 = c0_req_valid && (m_cnt[0] < MAX_OUTST);
      el1 = c1_req_valid && (m_cnt[1] < MAX_OUTST);
      if (el0 && el1) win = 1 - m_last;
      else win = el1 ? 1 : 0;
      g0 = can_load && el0 && (win == 0);
      g1 = can_load && el1 && (win == 1);
      exp_mrr = (sel == 1) ? c1_resp_ready : c0_resp_ready;
      hs = mem_resp_valid && exp_mrr;

      #1;
      chk("rnd_c0_ready", 128'(c0_req_ready), 128'(g0));
      chk("rnd_c1_ready", 128'(c1_req_ready), 128'(g1));
      chk("rnd_mem_resp_ready", 128'(mem_resp_ready), 128'(exp_mrr));
      chk("rnd_c0_resp_valid", 128'(c0_resp_valid), 128'(mem_resp_valid && sel == 0));
      chk("rnd_c1_resp_valid", 128'(c1_resp_valid), 128'(mem_resp_valid && sel == 1));

      if (g0 || g1) begin
        m_valid = 1'b1;
        m_we    = g1 ? c1_req_we   : c0_req_we;
        m_addr  = g1 ? c1_req_addr : c0_req_addr;
        m_data  = g1 ? c1_req_data : c0_req_data;
        m_id    = {1'(win), (g1 ? c1_req_id : c0_req_id)};
        m_last  = win;
        m_cnt[win] = m_cnt[win] + 1;
      end else if (mem_req_ready) begin
        m_valid = 1'b0;
      end
      if (hs) m_cnt[sel] = m_cnt[sel] - 1;

      tick();
      chk("rnd_mem_valid", 128'(mem_req_valid), 128'(m_valid));
      if (m_valid) begin
        chk("rnd_mem_we",   128'(mem_req_we),   128'(m_we));
        chk("rnd_mem_addr", 128'(mem_req_addr), 128'(m_addr));
        chk("rnd_mem_data", mem_req_data, m_data);
        chk("rnd_mem_id",   128'(mem_req_id),   128'(m_id));
      end
      chk("rnd_err", 128'(err), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l1_bus_arbiter.md
# l1_bus_arbiter

Two-client arbiter sharing the single L1 memory bus between the L1 instruction cache (client 0) and the L1 data cache (client 1). It selects one request per cycle round-robin and registers it onto the memory request channel. It tags each request with its source in the top ID bit and routes memory responses back to the owning client. Per-client outstanding-request counters bound in-flight traffic and flag protocol errors. It sits between the caches' bus ports and the memory/interconnect side.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 128, request/response data width (one cache line)
- ID_W, 2, client-side transaction ID width; memory-side ID is ID_W+1
- MAX_OUTST, 4, max in-flight requests per client (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cN_req_valid  in  1  client N (N=0,1) request valid
- cN_req_ready  out  1  client N request accepted this cycle
- cN_req_we  in  1  write request
- cN_req_addr  in  ADDR_W  request address
- cN_req_data  in  DATA_W  write data
- cN_req_id  in  ID_W  client transaction ID
- cN_resp_valid  out  1  response valid to client N
- cN_resp_ready  in  1  client N accepts response
- cN_resp_data  out  DATA_W  response data
- cN_resp_id  out  ID_W  response ID (low ID_W bits of mem_resp_id)
- mem_req_valid/ready  out/in  1  memory request handshake
- mem_req_we, mem_req_addr, mem_req_data  out  1/ADDR_W/DATA_W  registered request payload
- mem_req_id  out  ID_W+1  {client index, client id}
- mem_resp_valid/ready  in/out  1  memory response handshake
- mem_resp_data  in  DATA_W  response data
- mem_resp_id  in  ID_W+1  response ID; MSB selects client
- err  out  1  sticky protocol error

## Operation
- One-entry request register (slot) drives mem_req_*; mem_req_valid = slot full.
- Slot can load when empty or drained this cycle (mem_req_valid & mem_req_ready).
- Client N eligible: cN_req_valid & cnt[N] < MAX_OUTST.
- Arbitration: one eligible → it wins; both eligible → the client other than `last` wins. `last` updates to the winner on every accepted request.
- cN_req_ready = slot can load & client N is the winner; combinational, never asserted for a non-winner.
- On accept: slot ← {we, addr, data, {N, id}}; cnt[N]++.
- Slot payload stable while mem_req_valid & !mem_req_ready.
- Response path combinational: sel = mem_resp_id[ID_W]; c_sel_resp_valid = mem_resp_valid; other client's resp_valid = 0; mem_resp_ready = c_sel_resp_ready; data/id fanned to both clients.
- Response handshake for client N: cnt[N]--. Accept and response in the same cycle → cnt[N] unchanged.
- err set if a response handshake targets a client with cnt = 0 (counter held at 0). Cleared only by reset.

## Timing
- Reset (async assert, sync-to-clk release): slot empty, mem_req_valid=0, cnt[0]=cnt[1]=0, last=1 (client 0 first), err=0. mem_req_* payload registers reset to 0.
- Request latency: client handshake in cycle T → mem_req_valid in cycle T+1.
- Throughput: one request per cycle when memory holds mem_req_ready=1.
- Response latency: zero cycles, combinational.
- Full counter: client N blocked from cycle after cnt[N] reaches MAX_OUTST. A same-cycle response does not unblock it in that cycle.
- Counter width: clog2(MAX_OUTST+1); no wrap permitted.
- Reset mid-transaction: slot and counters cleared immediately; in-flight memory responses after reset release set err.

## Test plan
- Reset then c0 valid, addr=0x100, id=1 → c0_req_ready=1 in cycle 0; cycle 1 mem_req_valid=1, mem_req_addr=0x100, mem_req_id=3'b001.
- Both clients valid continuously, mem_req_ready=1 → grants alternate c0,c1,c0,c1; mem_req_id MSB sequence 0,1,0,1.
- mem_req_ready=0 for 3 cycles with slot full → payload stable; cN_req_ready=0 for both; on ready=1, next winner loads in the same cycle.
- c1 issues 4 requests with no responses (MAX_OUTST=4) → 5th held with c1_req_ready=0 while c0 still granted. A response with mem_resp_id=3'b110 → c1_resp_valid=1, c1_resp_id=2'b10, cnt[1]=3, c1 unblocked next cycle.
- Response id MSB=0 with c0_resp_ready=0 → mem_resp_ready=0, c1_resp_valid=0; c0 ready later → handshake, cnt[0] decrements.
- Response for c0 with cnt[0]=0 → err=1 next cycle and stays 1 until rst low.
